mem_byte_seq: RTL and testbench
===============================

MEM_BYTE_SEQ -- requirements
Module: mem_byte_seq

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (rising edge); rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have rdy  in  1  global enable; low freezes all state.
REQ-003 SHALL have req_valid  in  1  MEM stage requests a load/store.
REQ-004 SHALL have req_rw  in  1  1 = store, 0 = load.
REQ-005 SHALL have req_funct3  in  3  RISC-V funct3: [1:0] size (00 byte, 01 half, 1x word); [2] = 1 selects unsigned load.
REQ-006 SHALL have req_addr  in  32  byte address; req_wdata  in  32  store data, little-endian.
REQ-007 SHALL have mem_din  in  8  RAM read byte, valid one rdy cycle after its address was issued.
REQ-008 SHALL have data_ce  out  1, data_addr  out  32, data_out  out  8, data_rw  out  1; these feed the memory arbiter data port.
REQ-009 SHALL have busy  out  1  stall to pipeline; done  out  1  one-cycle completion pulse; rdata  out  32  extended load result.

Function
REQ-010 SHALL implement the states IDLE, XFER, LAST and DONE.
REQ-011 In IDLE with req_valid=1 and rdy=1, SHALL latch rw, funct3, addr and wdata, set cnt=0 and nbytes=1/2/4 from funct3[1:0], and go to XFER; busy SHALL assert from the next cycle.
REQ-012 In XFER: data_ce=1, data_addr=base+cnt (32-bit wrap), data_rw=latched rw, data_out=wdata byte[cnt]; cnt increments each rdy cycle.
REQ-013 In XFER for a load with cnt>=1: mem_din SHALL be captured into result byte[cnt-1].
REQ-014 When cnt==nbytes-1 in XFER, next state SHALL be DONE for a store and LAST for a load.
REQ-015 In LAST: data_ce=0, mem_din captured into byte[nbytes-1], next state DONE.
REQ-016 In DONE: done=1 for exactly one cycle, busy=0; next state IDLE; req_valid is ignored in DONE.
REQ-017 Loads: rdata SHALL be sign-extended from bit 8*nbytes-1 when funct3[2]=0 and zero-extended otherwise.
REQ-018 rdata SHALL be held from DONE until the next load completes.
REQ-019 Stores: rdata SHALL be unchanged.
REQ-020 Outside XFER: data_ce=0, data_rw=0, data_addr and data_out hold their last values.
REQ-021 Latency from the accept cycle T: a store of n bytes SHALL pulse done at T+n+1; a load of n bytes SHALL pulse done at T+n+2.
REQ-022 rdy=0 in any cycle SHALL hold state, cnt, captures and outputs; the memory is frozen likewise.
REQ-023 Misaligned addresses SHALL be legal and handled bytewise with no exception.
REQ-024 Reserved funct3 values 011, 110 and 111 SHALL be treated as a word access.
REQ-025 busy SHALL be 1 in XFER and LAST and 0 in IDLE and DONE.

Reset
REQ-026 On rst: state=IDLE, cnt=0; data_ce, data_rw, busy and done =0; data_addr, data_out and rdata =0.
REQ-027 rst mid-transfer SHALL abort immediately with no done pulse; a partially written store is not rolled back.
REQ-028 rst SHALL take priority over rdy.

Structure
REQ-029 State encoding, funct3 size/unsigned constants and zero32/zero8 SHALL live in define.v.
REQ-030 No sub-module is required; the load extender is an optional combinational sub-module, load_ext.

Verification
REQ-031 SW addr 0x100, wdata 0xA1B2C3D4 -> writes 0x100=D4, 0x101=C3, 0x102=B2, 0x103=A1; done at T+5.
REQ-032 LB from a byte holding 0x80 -> rdata 0xFFFFFF80; LBU from the same byte -> 0x00000080; done at T+3.
REQ-033 LH addr 0x201 (misaligned), bytes 0x34 then 0x12 -> rdata 0x00001234; addresses issued 0x201, 0x202.
REQ-034 LW with rdy low for 2 cycles mid-XFER -> same rdata as without stall; done delayed by exactly 2 cycles.
REQ-035 rst asserted during cnt=1 of an SW -> next cycle IDLE, data_ce=0, no done pulse; a following LW completes normally.
REQ-036 SB addr 0xFFFFFFFF -> single write to 0xFFFFFFFF; done at T+2; busy high for exactly one cycle.

Source files
------------

// File: rtl/mem_byte_seq_pkg.sv
// Shared constants for the byte-serial load/store sequencer: FSM states,
// funct3 size/unsigned decoding and the zero constants used at reset.
package mem_byte_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_LAST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam int         F3_UNSIGNED = 2;

    localparam logic [31:0] ZERO32 = 32'h0000_0000;
    localparam logic [7:0]  ZERO8  = 8'h00;

    // Index of the final byte (nbytes-1); reserved sizes fall into word.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 2'd0;
            SIZE_HALF: return 2'd1;
            default:   return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_seq_load_ext.sv
// Sign/zero extension of an assembled load word according to access size.
module mem_byte_seq_load_ext
    import mem_byte_seq_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (size)
            SIZE_BYTE: ext = {{24{raw[7]  & ~is_unsigned}}, raw[7:0]};
            SIZE_HALF: ext = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
            default:   ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_byte_seq.sv
// Turns one MEM-stage load/store into a sequence of single-byte RAM accesses,
// stalling the pipeline until the access completes.
module mem_byte_seq
    import mem_byte_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        req_valid,
    input  logic        req_rw,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  mem_din,
    output logic        data_ce,
    output logic [31:0] data_addr,
    output logic [7:0]  data_out,
    output logic        data_rw,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata
);

    state_t      state;
    logic [1:0]  cnt;
    logic [1:0]  last_cnt;
    logic        rw_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] result_q;

    logic [1:0]  cnt_nx;
    logic [1:0]  prev_idx;
    logic [31:0] raw_word;
    logic [31:0] ext_word;

    assign cnt_nx   = cnt + 2'd1;
    assign prev_idx = cnt - 2'd1;

    // The final load byte arrives during LAST; merge it before extending.
    always_comb begin
        raw_word = result_q;
        raw_word[{last_cnt, 3'b000} +: 8] = mem_din;
    end

    mem_byte_seq_load_ext u_load_ext (
        .raw         (raw_word),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .ext         (ext_word)
    );

    // Outputs are registered from the next state, so data_* line up with XFER.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 2'd0;
            last_cnt   <= 2'd0;
            rw_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
            base_q     <= ZERO32;
            wdata_q    <= ZERO32;
            result_q   <= ZERO32;
            data_ce    <= 1'b0;
            data_rw    <= 1'b0;
            data_addr  <= ZERO32;
            data_out   <= ZERO8;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= ZERO32;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        rw_q       <= req_rw;
                        size_q     <= req_funct3[1:0];
                        unsigned_q <= req_funct3[F3_UNSIGNED];
                        base_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        cnt        <= 2'd0;
                        last_cnt   <= last_index(req_funct3[1:0]);
                        data_ce    <= 1'b1;
                        data_rw    <= req_rw;
                        data_addr  <= req_addr;
                        data_out   <= req_wdata[7:0];
                        busy       <= 1'b1;
                        state      <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!rw_q && cnt != 2'd0)
                        result_q[{prev_idx, 3'b000} +: 8] <= mem_din;
                    cnt <= cnt_nx;
                    if (cnt == last_cnt) begin
                        data_ce <= 1'b0;
                        data_rw <= 1'b0;
                        if (rw_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_LAST;
                        end
                    end else begin
                        data_addr <= base_q + {30'd0, cnt_nx};
                        data_out  <= wdata_q[{cnt_nx, 3'b000} +: 8];
                    end
                end
                ST_LAST: begin
                    result_q <= raw_word;
                    rdata    <= ext_word;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_seq.sv
// Self-checking bench for mem_byte_seq: directed vector table, hand-written
// stall/reset sequences and randomized requests against a byte-array model.
module tb_mem_byte_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_rw = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [7:0]  mem_din = 8'h00;
    logic        data_ce;
    logic [31:0] data_addr;
    logic [7:0]  data_out;
    logic        data_rw;
    logic        busy;
    logic        done;
    logic [31:0] rdata;

    int checks = 0;
    int failures = 0;

    mem_byte_seq dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_din    (mem_din),
        .data_ce    (data_ce),
        .data_addr  (data_addr),
        .data_out   (data_out),
        .data_rw    (data_rw),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata)
    );

    always #5 clk = ~clk;

    // Byte RAM model (4 KiB window on the low address bits) with one-cycle read.
    logic [7:0]  mem [0:4095] = '{default: 8'h00};
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = 12'h0;
    logic [7:0]  pre_data = 8'h0;
    logic [31:0] rd_log [$];
    logic [31:0] wr_log [$];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (rdy && data_ce) begin
            if (data_rw) begin
                mem[data_addr[11:0]] <= data_out;
                wr_log.push_back(data_addr);
            end else begin
                mem_din <= mem[data_addr[11:0]];
                rd_log.push_back(data_addr);
            end
        end
    end

    typedef struct {
        logic        rw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre_en;
        logic [31:0] pre_word;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] model_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Reference load: assemble little-endian bytes, then extend arithmetically.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        int     n = nbytes_of(f3);
        longint v = 0;
        for (int i = 0; i < n; i++)
            v += longint'(mem[12'(addr + 32'(i))]) << (8 * i);
        if (!f3[2] && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] word);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pre_we   = 1'b1;
            pre_addr = 12'(addr + 32'(i));
            pre_data = word[8 * i +: 8];
        end
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one request; lat is the cycle offset of done from the accept cycle.
    task automatic run_req(input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int stall_at, input int stall_len,
                           output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        rd_log.delete();
        wr_log.delete();
        @(negedge clk);
        rdy        = 1'b1;
        req_valid  = 1'b1;
        req_rw     = rw;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            rdy = !(k >= stall_at && k < stall_at + stall_len);
            if (busy) busy_cycles++;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        rdy = 1'b1;
    endtask

    task automatic check_accesses(input string tag, input logic rw, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd);
        int n = nbytes_of(f3);
        if (rw) begin
            check({tag, "_wr_count"}, 32'(wr_log.size()), 32'(n));
            for (int i = 0; i < n && i < wr_log.size(); i++)
                check({tag, "_wr_addr"}, wr_log[i], addr + 32'(i));
            for (int i = 0; i < n; i++)
                check({tag, "_wr_byte"}, 32'(mem[12'(addr + 32'(i))]), 32'(wd[8 * i +: 8]));
        end else begin
            check({tag, "_rd_count"}, 32'(rd_log.size()), 32'(n));
            for (int i = 0; i < n && i < rd_log.size(); i++)
                check({tag, "_rd_addr"}, rd_log[i], addr + 32'(i));
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic pre_en, input logic [31:0] pre,
                                input logic [31:0] exp_rdata, input int lat, input int bsy);
        vec_t v;
        v.rw = rw; v.f3 = f3; v.addr = addr; v.wdata = wd;
        v.pre_en = pre_en; v.pre_word = pre;
        v.exp_rdata = exp_rdata; v.exp_lat = lat; v.exp_busy = bsy;
        return v;
    endfunction

    initial begin
        int lat, bcy, lat_ref, seen;
        logic [31:0] r_ref;

        vecs[0]  = mk(1'b0, 3'b000, 32'h0000_0300, 32'h0, 1'b1, 32'h0000_0080, 32'hFFFF_FF80, 3, 2);
        vecs[1]  = mk(1'b0, 3'b100, 32'h0000_0300, 32'h0, 1'b0, 32'h0,         32'h0000_0080, 3, 2);
        vecs[2]  = mk(1'b1, 3'b010, 32'h0000_0100, 32'hA1B2_C3D4, 1'b0, 32'h0, 32'h0000_0080, 5, 4);
        vecs[3]  = mk(1'b0, 3'b001, 32'h0000_0201, 32'h0, 1'b1, 32'h0000_1234, 32'h0000_1234, 4, 3);
        vecs[4]  = mk(1'b0, 3'b001, 32'h0000_0400, 32'h0, 1'b1, 32'h0000_FFFE, 32'hFFFF_FFFE, 4, 3);
        vecs[5]  = mk(1'b0, 3'b101, 32'h0000_0400, 32'h0, 1'b0, 32'h0,         32'h0000_FFFE, 4, 3);
        vecs[6]  = mk(1'b0, 3'b010, 32'h0000_0500, 32'h0, 1'b1, 32'h1122_3344, 32'h1122_3344, 6, 5);
        vecs[7]  = mk(1'b0, 3'b011, 32'h0000_0500, 32'h0, 1'b0, 32'h0,         32'h1122_3344, 6, 5);
        vecs[8]  = mk(1'b0, 3'b111, 32'h0000_0503, 32'h0, 1'b1, 32'h8765_4321, 32'h8765_4321, 6, 5);
        vecs[9]  = mk(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0000_005A, 1'b0, 32'h0, 32'h8765_4321, 2, 1);
        vecs[10] = mk(1'b1, 3'b001, 32'h0000_07FE, 32'h0000_BEEF, 1'b0, 32'h0, 32'h8765_4321, 3, 2);
        vecs[11] = mk(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0,         32'h0000_005A, 3, 2);

        // Reset state, with rdy low to confirm reset wins.
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_ce", 32'(data_ce), 32'd0);
        check("rst_data_rw", 32'(data_rw), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data_addr", data_addr, 32'h0);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        rdy = 1'b1;

        // Directed vector table.
        foreach (vecs[i]) begin
            if (vecs[i].pre_en) preload(vecs[i].addr, vecs[i].pre_word);
            run_req(vecs[i].rw, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 100, 0, lat, bcy);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check_accesses($sformatf("vec%0d", i), vecs[i].rw, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
        end
        model_rdata = 32'h0000_005A;

        // LW with rdy held low for two cycles in mid-transfer.
        preload(32'h0000_0600, 32'hDEAD_BEEF);
        run_req(1'b0, 3'b010, 32'h0000_0600, 32'h0, 100, 0, lat, bcy);
        check("lw_nostall_latency", 32'(lat), 32'd6);
        check("lw_nostall_rdata", rdata, 32'hDEAD_BEEF);
        run_req(1'b0, 3'b010, 32'h0000_0600, 32'h0, 2, 2, lat, bcy);
        check("lw_stall_latency", 32'(lat), 32'd8);
        check("lw_stall_rdata", rdata, 32'hDEAD_BEEF);
        check_accesses("lw_stall", 1'b0, 3'b010, 32'h0000_0600, 32'h0);

        // Reset during cnt=1 of a store: immediate abort, no done.
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0000_0700; req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_pre_addr", data_addr, 32'h0000_0701);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_data_ce", 32'(data_ce), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data_addr", data_addr, 32'h0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) seen++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(seen), 32'd0);
        preload(32'h0000_0710, 32'h0BAD_F00D);
        run_req(1'b0, 3'b010, 32'h0000_0710, 32'h0, 100, 0, lat, bcy);
        check("post_abort_latency", 32'(lat), 32'd6);
        check("post_abort_rdata", rdata, 32'h0BAD_F00D);
        model_rdata = 32'h0BAD_F00D;

        // Randomized requests against the byte-array model.
        for (int it = 0; it < 150; it++) begin
            logic        rw;
            logic [2:0]  f3;
            logic [31:0] addr, wd;
            int          s_at, s_len, n;
            rw    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            addr  = $urandom;
            wd    = $urandom;
            s_at  = $urandom_range(1, 6);
            s_len = $urandom_range(0, 3);
            n     = nbytes_of(f3);
            lat_ref = rw ? n + 1 : n + 2;
            if (s_at < lat_ref) lat_ref += s_len;
            r_ref = rw ? model_rdata : model_load(addr, f3);
            run_req(rw, f3, addr, wd, s_at, s_len, lat, bcy);
            check($sformatf("rnd%0d_latency", it), 32'(lat), 32'(lat_ref));
            check($sformatf("rnd%0d_rdata", it), rdata, r_ref);
            check_accesses($sformatf("rnd%0d", it), rw, f3, addr, wd);
            model_rdata = r_ref;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
